// File: rtl/sa_fifo_ctrl_16x14.sv
// ---------------------------------------------------------------------------
// sa_fifo_ctrl_16x14
// Controller for a 16-deep, 14-bit wide FIFO built around an external RAM.
// The RAM has a two-stage registered read path: ram_re latches the read
// address, ram_ore loads the output register one cycle later, and ram_dout
// is valid the cycle after that. Read data lands in a 3-entry output buffer
// that drives the read-side valid/ready interface.
//
// Ports
//   nvdla_core_clk      : clock, rising edge
//   nvdla_core_rstn     : synchronous active-low reset
//   wr_pvld/wr_prdy     : write-side handshake, payload wr_pd[13:0]
//   rd_pvld/rd_prdy     : read-side handshake, payload rd_pd[13:0]
//   fifo_count[4:0]     : registered total occupancy (RAM + in flight + buffer)
//   ram_wa/ram_we/ram_di: RAM write port
//   ram_ra/ram_re/ram_ore, ram_dout : RAM read port
//   pwrbus_ram_pd       : passed through to ram_pwrbus_ram_pd
// ---------------------------------------------------------------------------
module sa_fifo_ctrl_16x14 (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rstn,
    input  logic        wr_pvld,
    output logic        wr_prdy,
    input  logic [13:0] wr_pd,
    output logic        rd_pvld,
    input  logic        rd_prdy,
    output logic [13:0] rd_pd,
    output logic [4:0]  fifo_count,
    output logic [3:0]  ram_wa,
    output logic        ram_we,
    output logic [13:0] ram_di,
    output logic [3:0]  ram_ra,
    output logic        ram_re,
    output logic        ram_ore,
    input  logic [13:0] ram_dout,
    input  logic [31:0] pwrbus_ram_pd,
    output logic [31:0] ram_pwrbus_ram_pd
);

    logic [3:0]  wr_ptr;
    logic [3:0]  rd_ptr;
    logic [4:0]  ram_cnt;
    logic        s1;
    logic        s2;
    logic [13:0] obuf [0:2];
    logic [1:0]  obuf_head;
    logic [1:0]  obuf_tail;
    logic [1:0]  obuf_cnt;

    logic        wr_accept;
    logic        rd_pop;
    logic [2:0]  occupancy;
    logic [4:0]  ram_cnt_nxt;
    logic [1:0]  obuf_cnt_nxt;
    logic [4:0]  fifo_count_nxt;

    // Handshake and RAM control. Every control output is gated with the
    // reset input so nothing fires while reset is held, even before the
    // first reset edge has cleared the state.
    always_comb begin
        wr_prdy   = nvdla_core_rstn & (ram_cnt < 5'd16);
        wr_accept = wr_pvld & wr_prdy;
        ram_we    = wr_accept;
        ram_wa    = wr_ptr;
        ram_di    = wr_pd;

        rd_pvld   = nvdla_core_rstn & (obuf_cnt != 2'd0);
        rd_pop    = rd_pvld & rd_prdy;
        rd_pd     = obuf[obuf_head];

        // Credit check: words already committed to the output buffer after
        // this cycle's pop. Counting the pop lets a full pipeline keep
        // issuing one read per cycle without ever overflowing the buffer.
        occupancy = {2'b00, s1} + {2'b00, s2} + {1'b0, obuf_cnt} - {2'b00, rd_pop};
        ram_re    = nvdla_core_rstn & (ram_cnt != 5'd0) & (occupancy < 3'd3);
        ram_ra    = rd_ptr;
        ram_ore   = nvdla_core_rstn & s1;

        ram_cnt_nxt    = ram_cnt + {4'd0, wr_accept} - {4'd0, ram_re};
        obuf_cnt_nxt   = obuf_cnt + {1'b0, s2} - {1'b0, rd_pop};
        fifo_count_nxt = ram_cnt_nxt + {4'd0, ram_re} + {4'd0, s1} + {3'd0, obuf_cnt_nxt};

        ram_pwrbus_ram_pd = pwrbus_ram_pd;
    end

    // Control state: pointers, counters and the read pipeline valid bits.
    // fifo_count is loaded with the post-update occupancy so it always
    // describes the contents held in the current cycle.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            wr_ptr     <= 4'd0;
            rd_ptr     <= 4'd0;
            ram_cnt    <= 5'd0;
            s1         <= 1'b0;
            s2         <= 1'b0;
            obuf_head  <= 2'd0;
            obuf_tail  <= 2'd0;
            obuf_cnt   <= 2'd0;
            fifo_count <= 5'd0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 4'd1;
            end
            if (ram_re) begin
                rd_ptr <= rd_ptr + 4'd1;
            end
            ram_cnt <= ram_cnt_nxt;
            s1      <= ram_re;
            s2      <= s1;
            if (s2) begin
                obuf_tail <= (obuf_tail == 2'd2) ? 2'd0 : obuf_tail + 2'd1;
            end
            if (rd_pop) begin
                obuf_head <= (obuf_head == 2'd2) ? 2'd0 : obuf_head + 2'd1;
            end
            obuf_cnt   <= obuf_cnt_nxt;
            fifo_count <= fifo_count_nxt;
        end
    end

    // Output buffer storage needs no reset: entries are only visible
    // through obuf_cnt, which reset clears.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rstn && s2) begin
            obuf[obuf_tail] <= ram_dout;
        end
    end

endmodule

// File: tb/tb_sa_fifo_ctrl_16x14.sv
// ---------------------------------------------------------------------------
// tb_sa_fifo_ctrl_16x14
// Self-checking bench for sa_fifo_ctrl_16x14. Models the external RAM,
// keeps a queue of accepted-but-not-delivered words as the reference, and
// drives directed scenarios followed by randomized traffic with resets.
// ---------------------------------------------------------------------------
module tb_sa_fifo_ctrl_16x14;

    logic        clk = 1'b0;
    logic        rstn;
    logic        wr_pvld;
    logic        wr_prdy;
    logic [13:0] wr_pd;
    logic        rd_pvld;
    logic        rd_prdy;
    logic [13:0] rd_pd;
    logic [4:0]  fifo_count;
    logic [3:0]  ram_wa;
    logic        ram_we;
    logic [13:0] ram_di;
    logic [3:0]  ram_ra;
    logic        ram_re;
    logic        ram_ore;
    logic [13:0] ram_dout;
    logic [31:0] pwrbus;
    logic [31:0] pwrbus_out;

    always #5 clk = ~clk;

    sa_fifo_ctrl_16x14 dut (
        .nvdla_core_clk   (clk),
        .nvdla_core_rstn  (rstn),
        .wr_pvld          (wr_pvld),
        .wr_prdy          (wr_prdy),
        .wr_pd            (wr_pd),
        .rd_pvld          (rd_pvld),
        .rd_prdy          (rd_prdy),
        .rd_pd            (rd_pd),
        .fifo_count       (fifo_count),
        .ram_wa           (ram_wa),
        .ram_we           (ram_we),
        .ram_di           (ram_di),
        .ram_ra           (ram_ra),
        .ram_re           (ram_re),
        .ram_ore          (ram_ore),
        .ram_dout         (ram_dout),
        .pwrbus_ram_pd    (pwrbus),
        .ram_pwrbus_ram_pd(pwrbus_out)
    );

    // External RAM: address register on ram_re, output register on ram_ore
    logic [13:0] mem [0:15];
    logic [3:0]  ra_q;
    logic [13:0] dout_q;

    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_q <= ram_ra;
        if (ram_ore) dout_q <= mem[ra_q];
    end
    assign ram_dout = dout_q;

    // Reference state: words accepted and not yet delivered, in order
    logic [13:0] refq [$];
    int          checks = 0;
    int          errors = 0;
    int          wr_n = 0;
    int          rd_n = 0;
    int          pops = 0;
    bit          stalled_prev = 0;
    bit          first_seen = 0;
    logic [13:0] first_pop;

    logic        obs_prdy, obs_pvld, obs_we, obs_re, obs_ore;
    logic [13:0] obs_pd;
    logic [4:0]  obs_cnt;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check at the falling edge, then update
    // the reference with what happened at the rising edge.
    task automatic applyStimulus(input logic v, input logic [13:0] d, input logic r, input logic rst_n);
        wr_pvld = v;
        wr_pd   = d;
        rd_prdy = r;
        rstn    = rst_n;
        pwrbus  = $urandom;
        @(negedge clk);
        obs_prdy = wr_prdy;
        obs_pvld = rd_pvld;
        obs_we   = ram_we;
        obs_re   = ram_re;
        obs_ore  = ram_ore;
        obs_pd   = rd_pd;
        obs_cnt  = fifo_count;
        checkOutput("pwrbus", pwrbus_out, pwrbus);
        if (!rst_n) begin
            checkOutput("rst_wr_prdy", obs_prdy, 0);
            checkOutput("rst_rd_pvld", obs_pvld, 0);
            checkOutput("rst_ram_we", obs_we, 0);
            checkOutput("rst_ram_re", obs_re, 0);
            checkOutput("rst_ram_ore", obs_ore, 0);
        end else begin
            checkOutput("fifo_count", obs_cnt, refq.size());
            if (refq.size() == 0) begin
                checkOutput("empty_rd_pvld", obs_pvld, 0);
                checkOutput("empty_ram_re", obs_re, 0);
                checkOutput("empty_ram_ore", obs_ore, 0);
            end
            if (obs_pvld && refq.size() > 0) checkOutput("rd_pd", obs_pd, refq[0]);
            if (stalled_prev) checkOutput("stall_hold", obs_pvld, 1);
            if (refq.size() < 16) checkOutput("wr_prdy_room", obs_prdy, 1);
            if (refq.size() >= 19) checkOutput("wr_prdy_full", obs_prdy, 0);
            checkOutput("ram_we", obs_we, v & obs_prdy);
            if (obs_we) begin
                checkOutput("ram_wa", ram_wa, wr_n % 16);
                checkOutput("ram_di", ram_di, d);
            end
            if (obs_re) checkOutput("ram_ra", ram_ra, rd_n % 16);
        end
        @(posedge clk);
        if (!rst_n) begin
            refq.delete();
            wr_n = 0;
            rd_n = 0;
            stalled_prev = 0;
            first_seen = 0;
        end else begin
            if (obs_pvld && r) begin
                if (refq.size() > 0) void'(refq.pop_front());
                if (!first_seen) first_pop = obs_pd;
                first_seen = 1;
                pops++;
            end
            if (v && obs_prdy) begin
                refq.push_back(d);
                wr_n++;
            end
            if (obs_re) rd_n++;
            stalled_prev = obs_pvld && !r;
        end
        #1;
    endtask

    task automatic doReset();
        applyStimulus(0, 14'd0, 0, 0);
        applyStimulus(0, 14'd0, 0, 0);
    endtask

    int gaps;
    bit seen;

    initial begin
        wr_pvld = 0; wr_pd = 0; rd_prdy = 0; rstn = 0; pwrbus = 0;
        @(posedge clk);
        #1;
        doReset();

        // Single word latency
        for (int k = 0; k < 7; k++) begin
            applyStimulus(k == 0, 14'h1ABC, 1, 1);
            checkOutput("sw_ram_re", obs_re, k == 1);
            checkOutput("sw_ram_ore", obs_ore, k == 2);
            checkOutput("sw_rd_pvld", obs_pvld, k == 4);
            if (k == 4) checkOutput("sw_rd_pd", obs_pd, 14'h1ABC);
            if (k == 5) checkOutput("sw_count", obs_cnt, 0);
        end

        // Fill with no reads, then drain in order
        doReset();
        for (int k = 0; k < 22; k++) applyStimulus(1, 14'(wr_n), 0, 1);
        checkOutput("fill_accepts", wr_n, 19);
        checkOutput("fill_count", obs_cnt, 19);
        checkOutput("fill_re_idle", obs_re, 0);
        checkOutput("fill_prdy", obs_prdy, 0);
        pops = 0;
        for (int k = 0; k < 25; k++) applyStimulus(0, 14'd0, 1, 1);
        checkOutput("drain_pops", pops, 19);

        // Streaming at full rate, wrapping both pointers
        doReset();
        gaps = 0; seen = 0;
        for (int k = 0; k < 40; k++) begin
            applyStimulus(1, 14'(wr_n), 1, 1);
            if (obs_pvld) seen = 1;
            else if (seen) gaps++;
            if (k == 4) checkOutput("stream_first", obs_pvld, 1);
        end
        checkOutput("stream_gaps", gaps, 0);
        checkOutput("stream_pops", pops - 19, 36);

        // Backpressure: alternate ready every cycle
        doReset();
        pops = 0;
        for (int k = 0; k < 40; k++) applyStimulus(1, 14'(wr_n + 100), 14'(k) % 2 == 0, 1);
        for (int k = 0; k < 30; k++) applyStimulus(0, 14'd0, 1, 1);
        checkOutput("bp_drained", refq.size(), 0);
        checkOutput("bp_no_loss", pops, wr_n);

        // Reset mid-stream with ten words held
        doReset();
        for (int k = 0; k < 10; k++) applyStimulus(1, 14'(k + 50), 0, 1);
        applyStimulus(0, 14'd0, 0, 0);
        checkOutput("mid_pre_count", obs_cnt, 10);
        applyStimulus(1, 14'h0005, 1, 1);
        checkOutput("mid_post_count", obs_cnt, 0);
        checkOutput("mid_post_pvld", obs_pvld, 0);
        for (int k = 0; k < 8; k++) applyStimulus(0, 14'd0, 1, 1);
        checkOutput("mid_first_word", first_pop, 14'h0005);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 1500; k++) begin
            applyStimulus(($urandom % 4) != 0, 14'($urandom), ($urandom % 3) != 0,
                          ($urandom % 150) != 0);
        end
        for (int k = 0; k < 30; k++) applyStimulus(0, 14'd0, 1, 1);
        checkOutput("final_empty", obs_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
